// File: rtl/alu_issue_ctrl.sv
// Issue/control front end for a combinational ALU: accepts a request, decodes
// ALUOp/funct to the ALU control code, drives the ALU from registers and returns the result.
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [3:0]       alu_ctr,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   input1_reg;
    logic [WIDTH-1:0]   input2_reg;
    logic [3:0]         ctr_reg;
    logic               illegal_reg;
    logic [WIDTH-1:0]   data_reg;
    logic               zero_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               req_ready_reg;
    logic               resp_valid_reg;

    logic [3:0]         ctr_next;
    logic               illegal_next;

    always_comb begin
        ctr_next     = 4'b0000;
        illegal_next = 1'b0;
        case (req_aluop)
            2'b00: ctr_next = 4'b0010;
            2'b01: ctr_next = 4'b0110;
            2'b11: ctr_next = 4'b0001;
            default: begin
                case (req_funct)
                    6'b100000: ctr_next = 4'b0010;
                    6'b100010: ctr_next = 4'b0110;
                    6'b100100: ctr_next = 4'b0000;
                    6'b100101: ctr_next = 4'b0001;
                    6'b101010: ctr_next = 4'b0111;
                    6'b100111: ctr_next = 4'b1100;
                    default:   illegal_next = 1'b1;
                endcase
            end
        endcase
    end

    // Handshake outputs are registered alongside the state so they are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            input1_reg     <= '0;
            input2_reg     <= '0;
            ctr_reg        <= 4'b0000;
            illegal_reg    <= 1'b0;
            data_reg       <= '0;
            zero_reg       <= 1'b0;
            err_reg        <= 1'b0;
            count_reg      <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        input1_reg    <= req_a;
                        input2_reg    <= req_b;
                        ctr_reg       <= ctr_next;
                        illegal_reg   <= illegal_next;
                        req_ready_reg <= 1'b0;
                        state_reg     <= DRIVE;
                    end
                end
                DRIVE: begin
                    // An illegal funct reports a zero result regardless of what the ALU computed.
                    data_reg       <= illegal_reg ? '0 : alu_res;
                    zero_reg       <= illegal_reg | alu_zero;
                    err_reg        <= illegal_reg;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        count_reg      <= count_reg + 1'b1;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign alu_input1 = input1_reg;
    assign alu_input2 = input2_reg;
    assign alu_ctr    = ctr_reg;
    assign resp_data  = data_reg;
    assign resp_zero  = zero_reg;
    assign resp_err   = err_reg;
    assign op_count   = count_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop;
// a second instance with a 2-bit counter exercises the op_count wrap.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_aluop;
    logic [5:0]  req_funct;
    logic [31:0] req_a, req_b;
    logic        resp_ready;

    logic        req_ready, resp_valid, resp_zero, resp_err, alu_zero;
    logic [31:0] alu_input1, alu_input2, alu_res, resp_data;
    logic [3:0]  alu_ctr;
    logic [15:0] op_count;

    logic        s_req_ready, s_resp_valid, s_resp_zero, s_resp_err, s_alu_zero;
    logic [31:0] s_alu_input1, s_alu_input2, s_alu_res, s_resp_data;
    logic [3:0]  s_alu_ctr;
    logic [1:0]  s_op_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            4'b0000: alu_f = a & b;
            4'b0001: alu_f = a | b;
            4'b0010: alu_f = a + b;
            4'b0110: alu_f = a - b;
            4'b0111: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: alu_f = ~(a | b);
            default: alu_f = 32'd0;
        endcase
    endfunction

    assign alu_res    = alu_f(alu_input1, alu_input2, alu_ctr);
    assign alu_zero   = (alu_res == 32'd0);
    assign s_alu_res  = alu_f(s_alu_input1, s_alu_input2, s_alu_ctr);
    assign s_alu_zero = (s_alu_res == 32'd0);

    alu_issue_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_ctr(alu_ctr),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
        .op_count(op_count)
    );

    alu_issue_ctrl #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_input1(s_alu_input1), .alu_input2(s_alu_input2), .alu_ctr(s_alu_ctr),
        .alu_res(s_alu_res), .alu_zero(s_alu_zero),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready),
        .resp_data(s_resp_data), .resp_zero(s_resp_zero), .resp_err(s_resp_err),
        .op_count(s_op_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with resp_ready high; entered and left at posedge+1 in IDLE.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] ectr,
                          input logic [31:0] edata, input logic ezero, input logic eerr,
                          input logic [15:0] ecnt);
        req_aluop = op; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s idle_ready: got %b want 1", nm, req_ready);
        end
        tick();
        req_valid = 1'b0;
        tests_run++;
        if ({alu_ctr, alu_input1, alu_input2, req_ready, resp_valid} !== {ectr, a, b, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL %s drive: got ctr=%b in1=%h in2=%h rdy=%b vld=%b want ctr=%b in1=%h in2=%h rdy=0 vld=0",
                     nm, alu_ctr, alu_input1, alu_input2, req_ready, resp_valid, ectr, a, b);
        end
        tick();
        tests_run++;
        if ({resp_valid, resp_data, resp_zero, resp_err} !== {1'b1, edata, ezero, eerr}) begin
            tests_failed++;
            $display("FAIL %s resp: got vld=%b data=%h zero=%b err=%b want vld=1 data=%h zero=%b err=%b",
                     nm, resp_valid, resp_data, resp_zero, resp_err, edata, ezero, eerr);
        end
        tick();
        tests_run++;
        if ({resp_valid, req_ready, op_count} !== {1'b0, 1'b1, ecnt}) begin
            tests_failed++;
            $display("FAIL %s done: got vld=%b rdy=%b cnt=%0d want vld=0 rdy=1 cnt=%0d",
                     nm, resp_valid, req_ready, op_count, ecnt);
        end
        $display("[TB] %s a=%h b=%h ctr=%b data=%h zero=%b err=%b cnt=%0d",
                 nm, a, b, alu_ctr, resp_data, resp_zero, resp_err, op_count);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, resp_valid, alu_input1, alu_input2, alu_ctr, resp_data, resp_zero, resp_err, op_count}
            !== {1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b in1=%h in2=%h ctr=%b data=%h zero=%b err=%b cnt=%0d want 1 0 0 0 0 0 0 0 0",
                     req_ready, resp_valid, alu_input1, alu_input2, alu_ctr, resp_data, resp_zero, resp_err, op_count);
        end
        reset = 1'b0;
        tick();
        run_op("pre_reset_add", 2'b00, 6'b000000, 32'd7, 32'd9, 4'b0010, 32'd16, 1'b0, 1'b0, 16'd1);
        // Accept a request, then hit reset between edges while in DRIVE.
        req_aluop = 2'b01; req_a = 32'h55; req_b = 32'h11; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({req_ready, resp_valid, alu_input1, alu_input2, alu_ctr, resp_data, resp_zero, resp_err, op_count}
            !== {1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: got rdy=%b vld=%b in1=%h in2=%h ctr=%b data=%h zero=%b err=%b cnt=%0d want 1 0 0 0 0 0 0 0 0",
                     req_ready, resp_valid, alu_input1, alu_input2, alu_ctr, resp_data, resp_zero, resp_err, op_count);
        end
        #2;
        reset = 1'b0;
        tick();
        tests_run++;
        if ({resp_valid, op_count} !== {1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got vld=%b cnt=%0d want vld=0 cnt=0", resp_valid, op_count);
        end
        run_op("post_reset_or", 2'b11, 6'b000000, 32'hF0, 32'h0F, 4'b0001, 32'hFF, 1'b0, 1'b0, 16'd1);
    endtask

    task automatic test_and();
        run_op("rtype_and", 2'b10, 6'b100100, 32'h000000FF, 32'h0000007F, 4'b0000, 32'h0000007F, 1'b0, 1'b0, 16'd2);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_op("b2b_or",  2'b10, 6'b100101, 32'h3F, 32'h6F, 4'b0001, 32'h0000007F, 1'b0, 1'b0, 16'd1);
        run_op("b2b_add", 2'b10, 6'b100000, 32'h3F, 32'h6F, 4'b0010, 32'h000000AE, 1'b0, 1'b0, 16'd2);
        run_op("b2b_sub", 2'b10, 6'b100010, 32'h3F, 32'h6F, 4'b0110, 32'hFFFFFFD0, 1'b0, 1'b0, 16'd3);
        run_op("b2b_slt", 2'b10, 6'b101010, 32'h3F, 32'h6F, 4'b0111, 32'h00000001, 1'b0, 1'b0, 16'd4);
        run_op("b2b_nor", 2'b10, 6'b100111, 32'h3F, 32'h6F, 4'b1100, 32'hFFFFFF80, 1'b0, 1'b0, 16'd5);
    endtask

    task automatic test_sub_zero();
        run_op("sub_zero", 2'b01, 6'b100111, 32'h78, 32'h78, 4'b0110, 32'h0, 1'b1, 1'b0, 16'd6);
    endtask

    task automatic test_illegal();
        run_op("illegal_funct", 2'b10, 6'b000000, 32'h5, 32'h3, 4'b0000, 32'h0, 1'b1, 1'b1, 16'd7);
        run_op("after_illegal", 2'b00, 6'b000000, 32'h1, 32'h2, 4'b0010, 32'h3, 1'b0, 1'b0, 16'd8);
    endtask

    task automatic test_backpressure();
        apply_reset();
        resp_ready = 1'b0;
        req_aluop = 2'b00; req_funct = 6'b0; req_a = 32'h10; req_b = 32'h20; req_valid = 1'b1;
        tick();
        // Keep a different request pending; it must be ignored until IDLE.
        req_a = 32'h99;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({resp_valid, resp_data, req_ready, op_count, alu_input1} !== {1'b1, 32'h30, 1'b0, 16'd0, 32'h10}) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: got vld=%b data=%h rdy=%b cnt=%0d in1=%h want vld=1 data=30 rdy=0 cnt=0 in1=10",
                         i, resp_valid, resp_data, req_ready, op_count, alu_input1);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        tests_run++;
        if ({resp_valid, req_ready, op_count} !== {1'b0, 1'b1, 16'd1}) begin
            tests_failed++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b cnt=%0d want vld=0 rdy=1 cnt=1", resp_valid, req_ready, op_count);
        end
        $display("[TB] backpressure data=%h cnt=%0d", resp_data, op_count);
        run_op("wrap_op2", 2'b00, 6'b0, 32'd1, 32'd1, 4'b0010, 32'd2, 1'b0, 1'b0, 16'd2);
        run_op("wrap_op3", 2'b00, 6'b0, 32'd2, 32'd2, 4'b0010, 32'd4, 1'b0, 1'b0, 16'd3);
        run_op("wrap_op4", 2'b00, 6'b0, 32'd3, 32'd3, 4'b0010, 32'd6, 1'b0, 1'b0, 16'd4);
        run_op("wrap_op5", 2'b00, 6'b0, 32'd4, 32'd4, 4'b0010, 32'd8, 1'b0, 1'b0, 16'd5);
        tests_run++;
        if (s_op_count !== 2'd1) begin
            tests_failed++;
            $display("FAIL count_wrap: got %0d want 1", s_op_count);
        end
        $display("[TB] count_wrap small_cnt=%0d", s_op_count);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_aluop = 2'b00; req_funct = 6'b0; req_a = '0; req_b = '0;
        resp_ready = 1'b1;
        test_reset();
        test_and();
        test_back_to_back();
        test_sub_zero();
        test_illegal();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
